prv_intr_arbiter: RTL
=====================

Name: prv_intr_arbiter

Overview:
- Parametrised multi-source interrupt gateway and arbiter feeding the privilege unit's interrupt request.
- Each source has its own gateway, which latches the request and tracks claim and completion.
- Enabled pending sources are arbitrated by programmable priority against a threshold.
- Produces a registered intr/id/prio. The trap handler claims with a handshake and completes to re-arm the source.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- PRIO_W, 3, priority field width. Priority 0 means never interrupt.
- EDGE_MASK, '0 (NUM_SRC bits), bit i=1 makes source i edge-triggered (rising edge); bit i=0 makes it level-triggered.
- ID_W, $clog2(NUM_SRC+1), source ID width. ID 0 means none. Source i has ID i+1.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- src_irq  in  NUM_SRC  raw source request lines, synchronous to CLK
- src_en  in  NUM_SRC  per-source enable
- src_prio  in  NUM_SRC*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W]
- threshold  in  PRIO_W  winner must have prio strictly greater than this
- global_ie  in  1  global interrupt enable, gates intr only
- claim  in  1  one-cycle claim pulse
- claim_id  out  ID_W  combinational copy of intr_id, valid while claim=1
- complete  in  1  one-cycle completion pulse
- complete_id  in  ID_W  ID being completed
- pending  out  NUM_SRC  gateway state==PENDING per source, for the mip view
- intr  out  1  registered interrupt request
- intr_id  out  ID_W  registered winning ID
- intr_prio  out  PRIO_W  registered winning priority

Behaviour:
- Reset (async, RST=1): all gateways IDLE, repend=0, edge history=0, intr=0, intr_id=0, intr_prio=0. Reset asserted mid-service drops all claims; sources must re-request.
- Gateway states: IDLE, PENDING, IN_SERVICE.
  - IDLE->PENDING: trigger at a CLK edge. Level mode: src_irq=1. Edge mode: src_irq=1 and prev=0; prev is updated to src_irq every cycle.
  - PENDING->IN_SERVICE: claim=1 and claim_id equals this ID.
  - IN_SERVICE->IDLE: complete=1 and complete_id equals this ID. In edge mode with repend=1, go IN_SERVICE->PENDING instead and clear repend.
- Edge trigger while PENDING or IN_SERVICE sets repend (one deep; further edges are lost). Level sources ignore triggers outside IDLE.
- Complete with ID 0, ID > NUM_SRC, or a non-IN_SERVICE ID: ignored.
- Claim while intr_id=0: claim_id=0, no state change.
- Deasserting src_en while PENDING keeps the source pending but excludes it from arbitration. Level source dropping while PENDING stays pending (latched).
- Arbitration is combinational over state==PENDING && src_en && prio>threshold. Highest prio wins; ties go to the lowest index.
- Output registers load every cycle:
  - intr = winner_valid && global_ie
  - intr_id = winner ID, or 0
  - intr_prio = winner prio, or 0
  - intr_id and intr_prio update even when global_ie=0.
- Claim masking: in the cycle after a claim, arbitration excludes the claimed source, because its state is already IN_SERVICE.
- Latency: trigger sampled at edge k gives PENDING after k and intr=1 after edge k+1 (2 cycles from src_irq assertion).
- Claim at edge k gives the next winner, or intr=0, after edge k+1.
- Priority or threshold change is reflected after 1 edge. Complete with immediate re-trigger gives intr again 2 edges after complete for level mode, 1 edge for repend.

Decomposition:
- Package prv_intr_pkg holds:
  - gw_state_t enum {GW_IDLE, GW_PENDING, GW_IN_SERVICE}
  - localparams for ID 0 = none
  - a helper function returning src_prio slice i
- Sub-module prv_intr_gateway (one per source, generate loop): ports CLK, RST, irq, edge_mode, claim_hit, complete_hit; outputs state, pending.
- Arbiter tree and output registers live in the top module.

Test Plan (NUM_SRC=8, PRIO_W=3, threshold=0, global_ie=1, all enabled):
1. Level src 2 (ID 3) prio 5 asserted at cycle 0 -> intr=1, intr_id=3, intr_prio=5 after 2 edges. Claim returns claim_id=3 and intr=0 next cycle. complete_id=3 with src still high -> intr reasserts 2 edges later.
2. Sources 1 and 6 both prio 4 asserted together, source 4 prio 6 asserted together with them -> intr_id=5 first. After claiming 5, intr_id=2. After claiming 2, intr_id=7.
3. Edge src 0 (EDGE_MASK[0]=1) pulses twice while IN_SERVICE -> repend=1. Complete ID 1 -> state PENDING, intr_id=1 one edge later. The second extra edge is lost.
4. threshold=5 with src 3 at prio 5 -> intr=0, pending[3]=1. threshold changed to 4 -> intr=1, intr_id=4 after 1 edge. global_ie=0 -> intr=0 while intr_id stays 4.
5. src_en[3]=0 while PENDING -> intr=0, pending[3]=1. Complete ID 4 (not in service) ignored. Re-enable -> intr_id=4.
6. RST asserted mid-cycle with 3 sources IN_SERVICE -> outputs 0 immediately (async), pending=0. After release, level sources still high re-raise intr in 2 edges.

Source files
------------

// File: rtl/prv_intr_pkg.sv
// Shared types and helpers for the privilege-unit interrupt gateway/arbiter.
// Sources carry IDs starting at 1 so that 0 can mean "no interrupt".
package prv_intr_pkg;

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_t;

  localparam int ID_NONE      = 0;
  localparam int PRIO_W_MAX   = 8;
  localparam int SRC_MAX      = 31;
  localparam int PRIO_VEC_MAX = 256;

  // Extracts the priority field of source idx from a flattened vector.
  function automatic logic [PRIO_W_MAX-1:0] prio_of(
    input logic [PRIO_VEC_MAX-1:0] prio_vec,
    input int                      idx,
    input int                      w
  );
    logic [PRIO_W_MAX-1:0] res;
    res = '0;
    for (int b = 0; b < PRIO_W_MAX; b++) begin
      if (b < w) res[b] = prio_vec[idx*w + b];
    end
    return res;
  endfunction

endpackage

// File: rtl/prv_intr_gateway.sv
// Per-source gateway: latches a level or rising-edge request and tracks it
// through claim and completion, with a one-deep re-pend for edge sources.
module prv_intr_gateway
  import prv_intr_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      irq,
  input  logic      edge_mode,
  input  logic      claim_hit,
  input  logic      complete_hit,
  output gw_state_t state,
  output logic      pending
);

  gw_state_t state_reg;
  logic      prev_reg;
  logic      repend_reg;
  logic      trigger;

  assign trigger = edge_mode ? (irq & ~prev_reg) : irq;
  assign state   = state_reg;
  assign pending = (state_reg == GW_PENDING);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= GW_IDLE;
      prev_reg   <= 1'b0;
      repend_reg <= 1'b0;
    end else begin
      prev_reg <= irq;
      case (state_reg)
        GW_IDLE: begin
          if (trigger) state_reg <= GW_PENDING;
        end
        GW_PENDING: begin
          if (claim_hit) state_reg <= GW_IN_SERVICE;
          if (edge_mode && trigger) repend_reg <= 1'b1;
        end
        GW_IN_SERVICE: begin
          if (complete_hit) begin
            // A remembered edge re-arms the source straight back to pending.
            if (edge_mode && repend_reg) begin
              state_reg  <= GW_PENDING;
              repend_reg <= 1'b0;
            end else begin
              state_reg <= GW_IDLE;
            end
          end else if (edge_mode && trigger) begin
            repend_reg <= 1'b1;
          end
        end
        default: state_reg <= GW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prv_intr_arbiter.sv
// Multi-source interrupt gateway bank plus priority/threshold arbiter with
// registered intr/id/prio outputs and a claim/complete handshake.
module prv_intr_arbiter
  import prv_intr_pkg::*;
#(
  parameter int                 NUM_SRC   = 8,
  parameter int                 PRIO_W    = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
  parameter int                 ID_W      = $clog2(NUM_SRC + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC-1:0]        src_irq,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic                      global_ie,
  input  logic                      claim,
  output logic [ID_W-1:0]           claim_id,
  input  logic                      complete,
  input  logic [ID_W-1:0]           complete_id,
  output logic [NUM_SRC-1:0]        pending,
  output logic                      intr,
  output logic [ID_W-1:0]           intr_id,
  output logic [PRIO_W-1:0]         intr_prio
);

  logic [PRIO_VEC_MAX-1:0] prio_vec_ext;
  logic [PRIO_W-1:0]       src_prio_arr [NUM_SRC];
  gw_state_t               gw_state     [NUM_SRC];
  logic [NUM_SRC-1:0]      eligible;
  logic [NUM_SRC-1:0]      claim_hit;
  logic [NUM_SRC-1:0]      complete_hit;

  logic                    win_valid;
  logic [ID_W-1:0]         win_id;
  logic [PRIO_W-1:0]       win_prio;

  logic                    intr_reg;
  logic [ID_W-1:0]         intr_id_reg;
  logic [PRIO_W-1:0]       intr_prio_reg;

  assign prio_vec_ext = PRIO_VEC_MAX'(src_prio);
  assign claim_id     = intr_id_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      // IDs 0 and out-of-range never match, so stray claims/completes fall away.
      assign claim_hit[gi]    = claim && (intr_id_reg == ID_W'(gi + 1));
      assign complete_hit[gi] = complete && (complete_id == ID_W'(gi + 1));
      assign src_prio_arr[gi] = PRIO_W'(prio_of(prio_vec_ext, gi, PRIO_W));
      assign eligible[gi]     = (gw_state[gi] == GW_PENDING) && src_en[gi] &&
                                (src_prio_arr[gi] > threshold);

      prv_intr_gateway u_gw (
        .CLK          (CLK),
        .RST          (RST),
        .irq          (src_irq[gi]),
        .edge_mode    (EDGE_MASK[gi]),
        .claim_hit    (claim_hit[gi]),
        .complete_hit (complete_hit[gi]),
        .state        (gw_state[gi]),
        .pending      (pending[gi])
      );
    end
  endgenerate

  // Strict compare keeps the lowest index on equal priorities.
  always_comb begin
    win_valid = 1'b0;
    win_id    = ID_W'(ID_NONE);
    win_prio  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (!win_valid || (src_prio_arr[i] > win_prio))) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i + 1);
        win_prio  = src_prio_arr[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      intr_reg      <= 1'b0;
      intr_id_reg   <= '0;
      intr_prio_reg <= '0;
    end else begin
      intr_reg      <= win_valid && global_ie;
      intr_id_reg   <= win_id;
      intr_prio_reg <= win_prio;
    end
  end

  assign intr      = intr_reg;
  assign intr_id   = intr_id_reg;
  assign intr_prio = intr_prio_reg;

endmodule
